// File: rtl/brcomp_seq.sv
// Multi-cycle RV32 branch comparator: scans operands one DIGIT-wide chunk per cycle,
// MSB chunk first, and resolves br_less/br_equal/br_taken under valid/ready handshakes.
module brcomp_seq #(
  parameter int XLEN       = 32,
  parameter int DIGIT      = 8,
  parameter int EARLY_EXIT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [2:0]      br_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            br_less,
  output logic            br_equal,
  output logic            br_taken
);

  localparam int NCHUNK = XLEN / DIGIT;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0]   LAST_IDX = CW'(NCHUNK - 1);
  localparam logic [XLEN-1:0] MSB_BIT  = XLEN'(1) << (XLEN - 1);

  generate
    if (XLEN % DIGIT != 0) begin : g_bad_digit
      $fatal(1, "brcomp_seq: XLEN must be a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] a_reg, b_reg;
  logic [2:0]      op_reg;
  logic [CW-1:0]   cnt;
  logic            decided, less;

  logic [DIGIT-1:0] a_chunk, b_chunk;
  logic             differ, finish, decided_next, less_next, taken_next;

  // Operand registers shift left each CMP cycle, so the current chunk is always on top.
  assign a_chunk  = a_reg[XLEN-1 -: DIGIT];
  assign b_chunk  = b_reg[XLEN-1 -: DIGIT];
  assign in_ready = (state == IDLE);

  always_comb begin
    differ       = (a_chunk != b_chunk);
    decided_next = decided | differ;
    less_next    = decided ? less : (differ & (a_chunk < b_chunk));
    finish       = (cnt == LAST_IDX) || ((EARLY_EXIT != 0) && decided_next);
    case (op_reg)
      3'b000:          taken_next = !decided_next;
      3'b001:          taken_next = decided_next;
      3'b100, 3'b110:  taken_next = less_next;
      3'b101, 3'b111:  taken_next = !less_next;
      default:         taken_next = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = CMP;
      CMP:     if (finish)    state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= '0;
      cnt       <= '0;
      decided   <= 1'b0;
      less      <= 1'b0;
      out_valid <= 1'b0;
      br_less   <= 1'b0;
      br_equal  <= 1'b0;
      br_taken  <= 1'b0;
    end else if (flush) begin
      cnt       <= '0;
      decided   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          // Signed compares flip both sign bits so one unsigned scan serves all ops.
          a_reg   <= br_op[1] ? rs1_data : (rs1_data ^ MSB_BIT);
          b_reg   <= br_op[1] ? rs2_data : (rs2_data ^ MSB_BIT);
          op_reg  <= br_op;
          cnt     <= '0;
          decided <= 1'b0;
          less    <= 1'b0;
        end
        CMP: begin
          a_reg   <= a_reg << DIGIT;
          b_reg   <= b_reg << DIGIT;
          cnt     <= cnt + CW'(1);
          decided <= decided_next;
          less    <= less_next;
          if (finish) begin
            out_valid <= 1'b1;
            br_less   <= less_next;
            br_equal  <= !decided_next;
            br_taken  <= taken_next;
          end
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
